data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 40 ++++
 rtl/data_mem_responder_load_aligner.sv | 29 ++
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: RV32I load/store width
// codes, the responder FSM states and the common data width.
package data_mem_responder_pkg;

    localparam int DATA_W = 32;

    // RV32I funct3 width codes for loads and stores
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when a transaction must be rejected: illegal width code for the
    // operation, misaligned half/word access, or word index beyond the memory.
    function automatic logic txn_error(input logic        write,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input int unsigned depth_words);
        logic bad_code;
        logic misaligned;
        logic out_of_range;
        if (write) begin
            bad_code = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            bad_code = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                       ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= 32'(depth_words));
        return bad_code || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_aligner.sv
// Combinational load-data path: picks the addressed byte or halfword out of
// a memory word and sign- or zero-extends it according to the width code.
import data_mem_responder_pkg::*;

module load_aligner (
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection, then extension by width code; illegal codes yield 0
    always_comb begin
        sel_byte = word[8*addr +: 8];
        sel_half = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   data = {24'd0, sel_byte};
            F3_H:    data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   data = {16'd0, sel_half};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory that answers one RV32I load/store at a time with a
// fixed, parameterised stall between acceptance and response.
import data_mem_responder_pkg::*;

module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               accept;
    logic               enter_resp;

    logic               write_q;
    logic [2:0]         f3_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;

    logic               t_write;
    logic [2:0]         t_f3;
    logic [31:0]        t_addr;
    logic [31:0]        t_wdata;
    logic               t_err;
    logic               mem_we;
    logic [3:0]         be;
    logic [DATA_W-1:0]  wlanes;

    logic               rsp_err;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  ld_data;

    logic [DATA_W-1:0]  mem [DEPTH_WORDS];

    // State register, stall counter and request capture
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                write_q <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Next-state logic; enter_resp marks the edge on which a store commits
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With no stall the write edge is the acceptance edge, so the committing
    // transaction comes straight from the request inputs while idle.
    always_comb begin
        if (state == IDLE) begin
            t_write = req_write;
            t_f3    = req_funct3;
            t_addr  = req_addr;
            t_wdata = req_wdata;
        end else begin
            t_write = write_q;
            t_f3    = f3_q;
            t_addr  = addr_q;
            t_wdata = wdata_q;
        end
        t_err  = txn_error(t_write, t_f3, t_addr, DEPTH_WORDS);
        mem_we = reset_n && enter_resp && t_write && !t_err;
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        case (t_f3)
            F3_B: begin
                be     = 4'b0001 << t_addr[1:0];
                wlanes = {4{t_wdata[7:0]}};
            end
            F3_H: begin
                be     = t_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{t_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = t_wdata;
            end
        endcase
    end

    // Memory byte-lane writes
    always_ff @(posedge clock) begin
        // NOTE: the memory array is deliberately not reset; contents are undefined until written.
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[t_addr[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[addr_q[AW+1:2]];

    load_aligner u_load_aligner (
        .word   (rd_word),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (ld_data)
    );

    // Response outputs are driven only in RESP and are zero otherwise
    always_comb begin
        rsp_err    = txn_error(write_q, f3_q, addr_q, DEPTH_WORDS);
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && rsp_err;
        resp_rdata = (resp_valid && !rsp_err && !write_q) ? ld_data : '0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with WAIT_CYCLES of
// 0, 3 and 2 cover functional checks, stall timing and mid-transaction reset.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n     [3];
    logic        v_valid   [3];
    logic        v_write   [3];
    logic [2:0]  v_funct3  [3];
    logic [31:0] v_addr    [3];
    logic [31:0] v_wdata   [3];
    logic        v_ready   [3];
    logic        r_valid   [3];
    logic [31:0] r_rdata   [3];
    logic        r_err     [3];

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clock(clk), .reset_n(rst_n[0]), .req_valid(v_valid[0]), .req_write(v_write[0]),
        .req_funct3(v_funct3[0]), .req_addr(v_addr[0]), .req_wdata(v_wdata[0]),
        .req_ready(v_ready[0]), .resp_valid(r_valid[0]), .resp_rdata(r_rdata[0]), .resp_err(r_err[0])
    );

    data_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clock(clk), .reset_n(rst_n[1]), .req_valid(v_valid[1]), .req_write(v_write[1]),
        .req_funct3(v_funct3[1]), .req_addr(v_addr[1]), .req_wdata(v_wdata[1]),
        .req_ready(v_ready[1]), .resp_valid(r_valid[1]), .resp_rdata(r_rdata[1]), .resp_err(r_err[1])
    );

    data_mem_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clock(clk), .reset_n(rst_n[2]), .req_valid(v_valid[2]), .req_write(v_write[2]),
        .req_funct3(v_funct3[2]), .req_addr(v_addr[2]), .req_wdata(v_wdata[2]),
        .req_ready(v_ready[2]), .resp_valid(r_valid[2]), .resp_rdata(r_rdata[2]), .resp_err(r_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request, release it after acceptance, and report the
    // response and its latency in cycles (-1 if no response within budget).
    task automatic txn(input int i, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        @(negedge clk);
        v_valid[i]  = 1'b1;
        v_write[i]  = wr;
        v_funct3[i] = f3;
        v_addr[i]   = a;
        v_wdata[i]  = wd;
        n = 0;
        while (!v_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        v_valid[i] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (r_valid[i]) begin
                lat = c;
                rd  = r_rdata[i];
                er  = r_err[i];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input int i, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(i, wr, f3, a, wd, rd, er, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, " rdata"}, rd, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] ready_v, resp_v, ready_e, resp_e;
        int          acc_cnt, stray;

        for (int i = 0; i < 3; i++) begin
            rst_n[i]    = 1'b0;
            v_valid[i]  = 1'b0;
            v_write[i]  = 1'b0;
            v_funct3[i] = 3'd0;
            v_addr[i]   = 32'd0;
            v_wdata[i]  = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("reset ready",      {31'd0, v_ready[0]}, 32'd1);
        check("reset resp_valid", {31'd0, r_valid[0]}, 32'd0);
        check("reset rdata",      r_rdata[0], 32'd0);
        check("reset err",        {31'd0, r_err[0]}, 32'd0);

        // Release reset just after an edge so the first request meets the
        // very first edge with reset deasserted.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // WAIT_CYCLES = 0: function and error handling
        run("sw 0x10",      0, 1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1);
        run("lw 0x10",      0, 1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1);
        run("sw 0x00",      0, 1'b1, 3'd2, 32'h00,  32'h11111111, 32'h0,        1'b0, 1);
        run("sw 0x20",      0, 1'b1, 3'd2, 32'h20,  32'h00000000, 32'h0,        1'b0, 1);
        run("sb 0x21",      0, 1'b1, 3'd0, 32'h21,  32'hFFFFFF80, 32'h0,        1'b0, 1);
        run("lb 0x21",      0, 1'b0, 3'd0, 32'h21,  32'h0,        32'hFFFFFF80, 1'b0, 1);
        run("lbu 0x21",     0, 1'b0, 3'd4, 32'h21,  32'h0,        32'h00000080, 1'b0, 1);
        run("lw 0x20",      0, 1'b0, 3'd2, 32'h20,  32'h0,        32'h00008000, 1'b0, 1);
        run("sh 0x12",      0, 1'b1, 3'd1, 32'h12,  32'hFFFF1234, 32'h0,        1'b0, 1);
        run("lh 0x12",      0, 1'b0, 3'd1, 32'h12,  32'h0,        32'h00001234, 1'b0, 1);
        run("lhu 0x10",     0, 1'b0, 3'd5, 32'h10,  32'h0,        32'h0000BEEF, 1'b0, 1);
        run("lh 0x10",      0, 1'b0, 3'd1, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0, 1);
        run("lh 0x13 mis",  0, 1'b0, 3'd1, 32'h13,  32'h0,        32'h0,        1'b1, 1);
        run("sw 0x02 mis",  0, 1'b1, 3'd2, 32'h02,  32'h55555555, 32'h0,        1'b1, 1);
        run("lw 0x00 keep", 0, 1'b0, 3'd2, 32'h00,  32'h0,        32'h11111111, 1'b0, 1);
        run("lw oor",       0, 1'b0, 3'd2, 32'h400, 32'h0,        32'h0,        1'b1, 1);
        run("ld f3=3",      0, 1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1, 1);
        run("st f3=4",      0, 1'b1, 3'd4, 32'h20,  32'hAAAAAAAA, 32'h0,        1'b1, 1);
        run("lw 0x20 keep", 0, 1'b0, 3'd2, 32'h20,  32'h0,        32'h00008000, 1'b0, 1);
        run("lw 0x10 keep", 0, 1'b0, 3'd2, 32'h10,  32'h0,        32'h1234BEEF, 1'b0, 1);
        @(negedge clk);
        check("idle resp_valid", {31'd0, r_valid[0]}, 32'd0);
        check("idle rdata",      r_rdata[0], 32'd0);
        check("idle err",        {31'd0, r_err[0]}, 32'd0);

        // WAIT_CYCLES = 3: latency 4, then continuous requests 5 cycles apart
        run("w3 sw 0x00", 1, 1'b1, 3'd2, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0, 4);
        @(negedge clk);
        v_valid[1]  = 1'b1;
        v_write[1]  = 1'b0;
        v_funct3[1] = 3'd2;
        v_addr[1]   = 32'h00;
        acc_cnt     = 0;
        for (int k = 0; k < 16; k++) begin
            ready_v[k] = v_ready[1];
            resp_v[k]  = r_valid[1];
            ready_e[k] = (k % 5 == 0);
            resp_e[k]  = (k % 5 == 4);
            if (v_ready[1]) acc_cnt++;
            if (r_valid[1]) check("w3 rdata", r_rdata[1], 32'hCAFEF00D);
            @(negedge clk);
        end
        v_valid[1] = 1'b0;
        check("w3 ready pattern", {16'd0, ready_v}, {16'd0, ready_e});
        check("w3 resp pattern",  {16'd0, resp_v},  {16'd0, resp_e});
        check("w3 accept count",  32'(acc_cnt), 32'd4);

        // WAIT_CYCLES = 2: reset coinciding with the store's write edge
        run("w2 sw 0x40", 2, 1'b1, 3'd2, 32'h40, 32'hAAAAAAAA, 32'h0, 1'b0, 3);
        @(negedge clk);
        check("w2 ready before", {31'd0, v_ready[2]}, 32'd1);
        v_valid[2]  = 1'b1;
        v_write[2]  = 1'b1;
        v_funct3[2] = 3'd2;
        v_addr[2]   = 32'h40;
        v_wdata[2]  = 32'h12345678;
        @(negedge clk);
        v_valid[2] = 1'b0;
        check("w2 in wait ready", {31'd0, v_ready[2]}, 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(negedge clk);
        check("w2 rst ready",      {31'd0, v_ready[2]}, 32'd1);
        check("w2 rst resp_valid", {31'd0, r_valid[2]}, 32'd0);
        check("w2 rst rdata",      r_rdata[2], 32'd0);
        check("w2 rst err",        {31'd0, r_err[2]}, 32'd0);
        rst_n[2] = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r_valid[2]) stray++;
        end
        check("w2 no response", 32'(stray), 32'd0);
        run("w2 lw 0x40", 2, 1'b0, 3'd2, 32'h40, 32'h0, 32'hAAAAAAAA, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
